// File: rtl/sockit_spi_pkg.sv
// Shared definitions for the sockit SPI master: requester IDs, ID type and
// the command-path arbiter state encoding.
package sockit_spi_pkg;

   localparam int REQ_REG = 0;
   localparam int REQ_DMA = 1;
   localparam int REQ_XIP = 2;
   localparam int NR      = 3;

   typedef logic [$clog2(NR)-1:0] req_id_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_st_t;

endpackage

// File: rtl/sockit_spi_arb_tag.sv
// Tag FIFO: remembers which requester is owed each outstanding input word.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sockit_spi_arb_tag
   import sockit_spi_pkg::*;
#(
   parameter int RQD = 4,
   parameter int IDW = $bits(req_id_t)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [IDW-1:0]        push_id,
   input  logic                  pop,
   output logic [IDW-1:0]        head,
   output logic                  full,
   output logic                  empty,
   output logic [$clog2(RQD):0]  cnt
);

   localparam int AW = $clog2(RQD);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(RQD);
   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

   logic [IDW-1:0] r_mem [RQD];
   logic [AW:0]    r_wp;
   logic [AW:0]    r_rp;
   logic [AW:0]    w_cnt;
   logic           w_push;
   logic           w_pop;

   assign w_cnt  = r_wp - r_rp;
   assign full   = (w_cnt == FULL_CNT);
   assign empty  = (r_wp == r_rp);
   assign cnt    = w_cnt;
   assign head   = r_mem[r_rp[AW-1:0]];
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + PTR_ONE;
         if (w_pop)  r_rp <= r_rp + PTR_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RQD; i++) r_mem[i] <= '0;
      end else if (w_push) begin
         r_mem[r_wp[AW-1:0]] <= push_id;
      end
   end

endmodule

// File: rtl/sockit_spi_arb.sv
// Arbiter sharing the serializer command/response path between REG, DMA and
// XIP; the output path is locked per transaction, responses follow the tags.
module sockit_spi_arb #(
   parameter int NR  = 3,
   parameter int CDW = 32,
   parameter int RQD = 4,
   parameter int RR  = 0
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NR-1:0]         req_msk,
   input  logic [NR-1:0]         req_vld,
   input  logic [NR*CDW-1:0]     req_dat,
   input  logic [NR-1:0]         req_lst,
   input  logic [NR-1:0]         req_rsp,
   output logic [NR-1:0]         req_rdy,
   output logic [NR-1:0]         rsp_vld,
   output logic [CDW-1:0]        rsp_dat,
   input  logic [NR-1:0]         rsp_rdy,
   output logic                  qo_vld,
   output logic [CDW-1:0]        qo_dat,
   output logic                  qo_lst,
   output logic                  qo_rsp,
   input  logic                  qo_rdy,
   input  logic                  qi_vld,
   input  logic [CDW-1:0]        qi_dat,
   output logic                  qi_rdy,
   output logic [NR-1:0]         gnt,
   output logic [$clog2(RQD):0]  tag_cnt,
   output logic                  err
);

   import sockit_spi_pkg::*;

   localparam int IDW = (NR > 1) ? $clog2(NR) : 1;

   arb_st_t        r_st, w_st_nxt;
   logic [NR-1:0]  r_gnt, w_gnt_nxt;
   logic [IDW-1:0] r_own, w_own_nxt;
   logic           r_err;

   logic [NR-1:0]  w_cand;
   logic [IDW-1:0] w_win;
   logic           w_found;
   logic [NR-1:0]  w_sel;
   logic [NR-1:0]  w_hsel;
   logic [CDW-1:0] w_own_dat;
   logic           w_own_vld, w_own_lst, w_own_rsp;
   logic           w_ok, w_xfer, w_push, w_pop;
   logic [IDW-1:0] w_tag_head;
   logic           w_tag_full, w_tag_empty;

   assign w_cand = req_vld & req_msk;

   // RR=1 searches indices above the last owner first, then wraps from 0
   always_comb begin
      w_win   = '0;
      w_found = 1'b0;
      if (RR == 0) begin
         for (int r = 0; r < NR; r++) begin
            w_win = w_cand[r] ? IDW'(r) : w_win;
         end
      end else begin
         for (int r = 0; r < NR; r++) begin
            if (!w_found && w_cand[r] && (IDW'(r) > r_own)) begin
               w_win   = IDW'(r);
               w_found = 1'b1;
            end else begin
               w_found = w_found;
            end
         end
         for (int r = 0; r < NR; r++) begin
            if (!w_found && w_cand[r]) begin
               w_win   = IDW'(r);
               w_found = 1'b1;
            end else begin
               w_found = w_found;
            end
         end
      end
   end

   always_comb begin
      w_st_nxt  = r_st;
      w_gnt_nxt = r_gnt;
      w_own_nxt = r_own;
      case (r_st)
         ARB_IDLE: begin
            if (|w_cand) begin
               w_st_nxt  = ARB_LOCK;
               w_own_nxt = w_win;
               for (int r = 0; r < NR; r++) w_gnt_nxt[r] = (w_win == IDW'(r));
            end else begin
               w_gnt_nxt = '0;
            end
         end
         ARB_LOCK: begin
            if (w_xfer && w_own_lst) begin
               w_st_nxt  = ARB_IDLE;
               w_gnt_nxt = '0;
            end else begin
               w_st_nxt  = ARB_LOCK;
            end
         end
         default: begin
            w_st_nxt  = ARB_IDLE;
            w_gnt_nxt = '0;
         end
      endcase
   end

   // owner select for the command mux, head-tag select for the response demux
   always_comb begin
      w_sel     = '0;
      w_hsel    = '0;
      w_own_dat = '0;
      for (int r = 0; r < NR; r++) begin
         w_sel[r]  = (r_st == ARB_LOCK) && (r_own == IDW'(r));
         w_hsel[r] = !w_tag_empty && (w_tag_head == IDW'(r));
         w_own_dat = w_own_dat | (req_dat[r*CDW +: CDW] & {CDW{w_sel[r]}});
      end
   end

   assign w_own_vld = |(req_vld & w_sel);
   assign w_own_lst = |(req_lst & w_sel);
   assign w_own_rsp = |(req_rsp & w_sel);
   // a response beat may not leave unless a tag slot is free
   assign w_ok      = ~w_own_rsp | ~w_tag_full;
   assign w_xfer    = qo_vld & qo_rdy;
   assign w_push    = w_xfer & w_own_rsp;

   assign qo_vld  = w_own_vld & w_ok;
   assign qo_dat  = w_own_dat;
   assign qo_lst  = w_own_lst;
   assign qo_rsp  = w_own_rsp;
   assign req_rdy = w_sel & {NR{qo_rdy & w_ok}};

   // with no tag outstanding the word is swallowed and flagged
   assign rsp_vld = w_hsel & {NR{qi_vld}};
   assign rsp_dat = qi_dat;
   assign qi_rdy  = w_tag_empty ? qi_vld : |(rsp_rdy & w_hsel);
   assign w_pop   = qi_vld & qi_rdy & ~w_tag_empty;

   assign gnt = r_gnt;
   assign err = r_err;

   // arbitration state, last owner and sticky error flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_st  <= ARB_IDLE;
         r_gnt <= '0;
         r_own <= '0;
         r_err <= 1'b0;
      end else begin
         r_st  <= w_st_nxt;
         r_gnt <= w_gnt_nxt;
         r_own <= w_own_nxt;
         r_err <= r_err | (qi_vld & w_tag_empty);
      end
   end

   sockit_spi_arb_tag #(
      .RQD (RQD),
      .IDW (IDW)
   ) u_tag (
      .clk     (clk),
      .rst     (rst),
      .push    (w_push),
      .push_id (r_own),
      .pop     (w_pop),
      .head    (w_tag_head),
      .full    (w_tag_full),
      .empty   (w_tag_empty),
      .cnt     (tag_cnt)
   );

endmodule

// File: tb/tb_sockit_spi_arb.sv
// Bench: two arbiters (fixed priority and round-robin) against a transaction
// level model with a tag queue, directed scenarios then random traffic.
module tb_sockit_spi_arb;

   localparam int NR  = 3;
   localparam int CDW = 32;
   localparam int RQD = 4;
   localparam int CW  = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [NR-1:0]     msk [2], vld [2], lst [2], rsp [2], rrdy [2];
   logic [NR*CDW-1:0] dat [2];
   logic              qordy [2], qivld [2];
   logic [CDW-1:0]    qidat [2];

   logic [NR-1:0]     o_rrdy [2], o_rvld [2], o_gnt [2];
   logic [CDW-1:0]    o_rdat [2], o_qdat [2];
   logic              o_qvld [2], o_qlst [2], o_qrsp [2], o_qirdy [2], o_err [2];
   logic [CW-1:0]     o_cnt [2];

   logic [NR-1:0]     e_rrdy [2], e_rvld [2], e_gnt [2];
   logic [CDW-1:0]    e_rdat [2], e_qdat [2];
   logic              e_qvld [2], e_qlst [2], e_qrsp [2], e_qirdy [2], e_err [2];
   logic [CW-1:0]     e_cnt [2];

   int m_own [2];
   int m_last [2];
   int m_tn [2];
   int m_tq [2][RQD+1];
   bit m_err [2];

   int checks = 0;
   int errors = 0;

   sockit_spi_arb #(.NR(NR), .CDW(CDW), .RQD(RQD), .RR(0)) u_fix (
      .clk(clk), .rst(rst), .req_msk(msk[0]), .req_vld(vld[0]), .req_dat(dat[0]),
      .req_lst(lst[0]), .req_rsp(rsp[0]), .req_rdy(o_rrdy[0]), .rsp_vld(o_rvld[0]),
      .rsp_dat(o_rdat[0]), .rsp_rdy(rrdy[0]), .qo_vld(o_qvld[0]), .qo_dat(o_qdat[0]),
      .qo_lst(o_qlst[0]), .qo_rsp(o_qrsp[0]), .qo_rdy(qordy[0]), .qi_vld(qivld[0]),
      .qi_dat(qidat[0]), .qi_rdy(o_qirdy[0]), .gnt(o_gnt[0]), .tag_cnt(o_cnt[0]),
      .err(o_err[0]));

   sockit_spi_arb #(.NR(NR), .CDW(CDW), .RQD(RQD), .RR(1)) u_rr (
      .clk(clk), .rst(rst), .req_msk(msk[1]), .req_vld(vld[1]), .req_dat(dat[1]),
      .req_lst(lst[1]), .req_rsp(rsp[1]), .req_rdy(o_rrdy[1]), .rsp_vld(o_rvld[1]),
      .rsp_dat(o_rdat[1]), .rsp_rdy(rrdy[1]), .qo_vld(o_qvld[1]), .qo_dat(o_qdat[1]),
      .qo_lst(o_qlst[1]), .qo_rsp(o_qrsp[1]), .qo_rdy(qordy[1]), .qi_vld(qivld[1]),
      .qi_dat(qidat[1]), .qi_rdy(o_qirdy[1]), .gnt(o_gnt[1]), .tag_cnt(o_cnt[1]),
      .err(o_err[1]));

   task automatic chk(input string nm, input int i, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s inst%0d act=%0h exp=%0h at %0t", nm, i, a, e, $time);
      end
   endtask

   task automatic model_reset(input int i);
      m_own[i]  = -1;
      m_last[i] = 0;
      m_tn[i]   = 0;
      m_err[i]  = 1'b0;
   endtask

   // expected outputs from the current model state and the applied inputs
   task automatic model_eval(input int i);
      int o;
      int h;
      bit ok;
      o = m_own[i];
      e_gnt[i] = '0; e_rrdy[i] = '0; e_rvld[i] = '0;
      e_qvld[i] = 1'b0; e_qdat[i] = '0; e_qlst[i] = 1'b0; e_qrsp[i] = 1'b0;
      if (o >= 0) begin
         ok = (rsp[i][o] == 1'b0) || (m_tn[i] < RQD);
         e_gnt[i][o]  = 1'b1;
         e_qvld[i]    = vld[i][o] && ok;
         e_qdat[i]    = dat[i][o*CDW +: CDW];
         e_qlst[i]    = lst[i][o];
         e_qrsp[i]    = rsp[i][o];
         e_rrdy[i][o] = qordy[i] && ok;
      end
      if (m_tn[i] > 0) begin
         h = m_tq[i][0];
         e_rvld[i][h] = qivld[i];
         e_qirdy[i]   = rrdy[i][h];
      end else begin
         e_qirdy[i]   = qivld[i];
      end
      e_rdat[i] = qidat[i];
      e_cnt[i]  = CW'(m_tn[i]);
      e_err[i]  = m_err[i];
   endtask

   task automatic model_step(input int i);
      int pre;
      int c;
      logic [NR-1:0] cand;
      pre = m_tn[i];
      if (qivld[i] && pre == 0) m_err[i] = 1'b1;
      if (qivld[i] && e_qirdy[i] && pre > 0) begin
         for (int k = 0; k < RQD; k++) m_tq[i][k] = m_tq[i][k+1];
         m_tn[i]--;
      end
      if (m_own[i] >= 0) begin
         if (e_qvld[i] && qordy[i]) begin
            if (e_qrsp[i]) begin
               m_tq[i][m_tn[i]] = m_own[i];
               m_tn[i]++;
            end
            if (e_qlst[i]) m_own[i] = -1;
         end
      end else begin
         cand = vld[i] & msk[i];
         if (cand != '0) begin
            c = -1;
            if (i == 0) begin
               for (int r = NR-1; r >= 0; r--) if (c < 0 && cand[r]) c = r;
            end else begin
               for (int k = 1; k <= NR; k++) if (c < 0 && cand[(m_last[i]+k) % NR]) c = (m_last[i]+k) % NR;
            end
            m_own[i]  = c;
            m_last[i] = c;
         end
      end
   endtask

   task automatic compare(input int i);
      chk("req_rdy", i, 64'(o_rrdy[i]), 64'(e_rrdy[i]));
      chk("rsp_vld", i, 64'(o_rvld[i]), 64'(e_rvld[i]));
      chk("rsp_dat", i, 64'(o_rdat[i]), 64'(e_rdat[i]));
      chk("qo_vld",  i, 64'(o_qvld[i]), 64'(e_qvld[i]));
      chk("qo_dat",  i, 64'(o_qdat[i]), 64'(e_qdat[i]));
      chk("qo_lst",  i, 64'(o_qlst[i]), 64'(e_qlst[i]));
      chk("qo_rsp",  i, 64'(o_qrsp[i]), 64'(e_qrsp[i]));
      chk("qi_rdy",  i, 64'(o_qirdy[i]), 64'(e_qirdy[i]));
      chk("gnt",     i, 64'(o_gnt[i]), 64'(e_gnt[i]));
      chk("tag_cnt", i, 64'(o_cnt[i]), 64'(e_cnt[i]));
      chk("err",     i, 64'(o_err[i]), 64'(e_err[i]));
   endtask

   // one cycle: compare before the edge, advance the model on the edge
   task automatic cyc();
      #1;
      for (int i = 0; i < 2; i++) begin
         model_eval(i);
         compare(i);
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rst) model_step(i);
         else     model_reset(i);
      end
      @(negedge clk);
   endtask

   initial begin
      int acc;
      int ng;
      logic [NR-1:0] ord [8];

      for (int i = 0; i < 2; i++) begin
         msk[i] = 3'b111; vld[i] = '0; lst[i] = '0; rsp[i] = '0; rrdy[i] = '0;
         dat[i] = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
         qordy[i] = 1'b0; qivld[i] = 1'b0; qidat[i] = '0;
         model_reset(i);
      end

      #3;
      chk("rst_gnt",  0, 64'(o_gnt[0]), 64'h0);
      chk("rst_cnt",  0, 64'(o_cnt[0]), 64'h0);
      chk("rst_err",  0, 64'(o_err[0]), 64'h0);
      chk("rst_qvld", 0, 64'(o_qvld[0]), 64'h0);
      chk("rst_qdat", 0, 64'(o_qdat[0]), 64'h0);
      @(negedge clk);
      cyc();
      rst = 1'b1;
      cyc();

      // fixed priority: XIP beats REG, one idle bubble between owners
      vld[0] = 3'b101; lst[0] = 3'b101; qordy[0] = 1'b1;
      #1; chk("idle_gnt", 0, 64'(o_gnt[0]), 64'h0);
      cyc();
      #1; chk("prio_gnt", 0, 64'(o_gnt[0]), 64'h4);
      chk("prio_qdat", 0, 64'(o_qdat[0]), 64'h3333_0002);
      cyc();
      vld[0] = 3'b001;
      #1; chk("bubble_gnt", 0, 64'(o_gnt[0]), 64'h0);
      cyc();
      #1; chk("next_gnt", 0, 64'(o_gnt[0]), 64'h1);
      cyc();
      vld[0] = '0; lst[0] = '0;
      cyc();

      // DMA fills the tag FIFO and stalls without losing the beat
      vld[0] = 3'b010; rsp[0] = 3'b010;
      acc = 0;
      repeat (7) begin
         #1; acc += (o_rrdy[0][1] && o_qvld[0]) ? 1 : 0;
         cyc();
      end
      chk("full_acc", 0, 64'(acc), 64'd4);
      #1; chk("full_cnt", 0, 64'(o_cnt[0]), 64'd4);
      chk("full_qvld", 0, 64'(o_qvld[0]), 64'h0);
      chk("full_rdy", 0, 64'(o_rrdy[0]), 64'h0);
      qivld[0] = 1'b1; qidat[0] = 32'h1234_5678; rrdy[0] = 3'b010;
      #1; chk("pop_rvld", 0, 64'(o_rvld[0]), 64'h2);
      cyc();
      qivld[0] = 1'b0;
      #1; chk("fifth_rdy", 0, 64'(o_rrdy[0]), 64'h2);
      chk("fifth_qvld", 0, 64'(o_qvld[0]), 64'h1);
      chk("fifth_cnt", 0, 64'(o_cnt[0]), 64'd3);
      cyc();
      lst[0] = 3'b010; rrdy[0] = 3'b111;
      repeat (9) begin
         qivld[0] = (m_tn[0] > 0);
         qidat[0] = $urandom;
         if (m_own[0] < 0) vld[0] = '0;
         cyc();
      end
      rsp[0] = '0; lst[0] = '0; rrdy[0] = '0; qivld[0] = 1'b0;

      // DMA responses keep flowing to DMA while XIP owns the output path
      vld[0] = 3'b010; rsp[0] = 3'b010;
      cyc(); cyc();
      lst[0] = 3'b010;
      cyc();
      vld[0] = 3'b100; rsp[0] = '0; lst[0] = '0;
      cyc();
      qivld[0] = 1'b1; qidat[0] = 32'hA5A5_A5A5; rrdy[0] = 3'b010;
      #1; chk("xip_gnt", 0, 64'(o_gnt[0]), 64'h4);
      chk("xip_qvld", 0, 64'(o_qvld[0]), 64'h1);
      chk("dma_rvld0", 0, 64'(o_rvld[0]), 64'h2);
      chk("dma_rdat0", 0, 64'(o_rdat[0]), 64'hA5A5_A5A5);
      cyc();
      qidat[0] = 32'h5A5A_5A5A; lst[0] = 3'b100;
      #1; chk("dma_rvld1", 0, 64'(o_rvld[0]), 64'h2);
      chk("dma_rdat1", 0, 64'(o_rdat[0]), 64'h5A5A_5A5A);
      cyc();
      qivld[0] = 1'b0; vld[0] = '0; lst[0] = '0; rrdy[0] = '0;
      cyc();

      // stray input word with no tag outstanding
      qivld[0] = 1'b1;
      #1; chk("stray_qirdy", 0, 64'(o_qirdy[0]), 64'h1);
      chk("stray_rvld", 0, 64'(o_rvld[0]), 64'h0);
      cyc();
      qivld[0] = 1'b0;
      #1; chk("err_set", 0, 64'(o_err[0]), 64'h1);
      cyc(); cyc();
      #1; chk("err_hold", 0, 64'(o_err[0]), 64'h1);

      // round-robin order from reset with everyone always requesting
      vld[1] = 3'b111; lst[1] = 3'b111; qordy[1] = 1'b1;
      ng = 0;
      for (int k = 0; k < 8; k++) ord[k] = '0;
      repeat (8) begin
         #1;
         if (o_gnt[1] != '0 && ng < 8) begin
            ord[ng] = o_gnt[1];
            ng++;
         end
         cyc();
      end
      chk("rr_ngnt", 1, 64'(ng), 64'd4);
      chk("rr_gnt0", 1, 64'(ord[0]), 64'h2);
      chk("rr_gnt1", 1, 64'(ord[1]), 64'h4);
      chk("rr_gnt2", 1, 64'(ord[2]), 64'h1);
      chk("rr_gnt3", 1, 64'(ord[3]), 64'h2);
      vld[1] = '0; lst[1] = '0;
      repeat (2) cyc();

      // asynchronous reset in the middle of a locked transaction
      vld[0] = 3'b010; rsp[0] = 3'b010;
      cyc(); cyc(); cyc();
      vld[0] = '0;
      #1; chk("pre_cnt", 0, 64'(o_cnt[0]), 64'd2);
      chk("pre_gnt", 0, 64'(o_gnt[0]), 64'h2);
      rst = 1'b0;
      #1;
      model_reset(0); model_reset(1);
      chk("arst_gnt", 0, 64'(o_gnt[0]), 64'h0);
      chk("arst_cnt", 0, 64'(o_cnt[0]), 64'h0);
      chk("arst_qvld", 0, 64'(o_qvld[0]), 64'h0);
      chk("arst_err", 0, 64'(o_err[0]), 64'h0);
      rsp[0] = '0;
      cyc();
      rst = 1'b1;
      vld[0] = 3'b001; lst[0] = 3'b001;
      cyc();
      #1; chk("post_gnt", 0, 64'(o_gnt[0]), 64'h1);
      cyc();
      vld[0] = '0; lst[0] = '0;
      cyc();

      // random traffic on both arbiters
      repeat (3000) begin
         for (int i = 0; i < 2; i++) begin
            msk[i]   = ($urandom_range(0, 3) == 0) ? NR'($urandom) : 3'b111;
            vld[i]   = NR'($urandom);
            dat[i]   = {$urandom, $urandom, $urandom};
            for (int r = 0; r < NR; r++) lst[i][r] = ($urandom_range(0, 2) == 0);
            rsp[i]   = NR'($urandom);
            rrdy[i]  = NR'($urandom);
            qordy[i] = ($urandom_range(0, 3) != 0);
            qivld[i] = ($urandom_range(0, 1) == 0);
            qidat[i] = $urandom;
         end
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
